// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader that fills instruction memory and gates core reset.
// Frame: LEN_LO, LEN_HI, 4*N little-endian payload bytes, then the XOR of all payload bytes.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Largest accepted word count is the full memory capacity.
    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [7:0]          xor_q, xor_d;
    logic [23:0]         asm_q, asm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                accept;
    logic [15:0]         len_full;
    logic [16:0]         idx_next_ext;

    assign in_ready     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);
    assign busy         = in_ready;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign core_rst     = (state_q != S_DONE);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = idx_q;

    assign accept       = in_valid && in_ready;
    assign len_full     = {in_data, len_q[7:0]};
    assign idx_next_ext = 17'(idx_q) + 17'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            xor_q   <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            xor_q   <= xor_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        xor_d   = xor_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    len_d   = '0;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    xor_d   = '0;
                end
            end

            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    if ({1'b0, len_full} > CAP) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    xor_d  = xor_q ^ in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            // Fourth byte completes the word; the write goes out registered next cycle.
                            we_d    = 1'b1;
                            addr_d  = idx_q[ADDR_W-1:0];
                            wdata_d = {in_data, asm_q};
                            idx_d   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
                            if (idx_next_ext == {1'b0, len_q}) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end

            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] img [0:255];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];

    prog_loader #(.ADDR_W(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_rst     (core_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Capture every write; words_loaded must already count the word being written.
    always @(negedge CLK) begin
        if (!RST && mem_we) begin
            wa_q.push_back({24'h0, mem_addr});
            wd_q.push_back(mem_wdata);
            check("wl_with_we", {23'h0, words_loaded}, {24'h0, mem_addr} + 32'd1);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge CLK); #1; end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        forever begin
            @(negedge CLK);
            if (in_ready) begin
                @(posedge CLK); #1;
                break;
            end
            n++;
            if (n > 50) begin
                check("byte_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] cs, input int gapmax, input int start_at);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        for (int k = 0; k < 4 * n; k++) begin
            logic [31:0] w;
            w = img[k / 4];
            if (k == start_at) begin
                in_valid = 1'b0;
                pulse_start();
                check("start_mid_busy", {31'h0, busy}, 32'd1);
            end
            send_byte(w[8 * (k % 4) +: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
        send_byte(cs, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        in_valid = 1'b0;
    endtask

    task automatic check_two_words(input string tag);
        check({tag, "_nwr"}, wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_a0"}, wa_q[0], 32'd0);
            check({tag, "_d0"}, wd_q[0], 32'h0000_0013);
            check({tag, "_a1"}, wa_q[1], 32'd1);
            check({tag, "_d1"}, wd_q[1], 32'h0010_0093);
        end
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        logic [7:0] cs;
        int bad;

        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;

        // Reset values while held and after release.
        #2;
        check("rst_in_ready", {31'h0, in_ready}, 32'd0);
        check("rst_mem_we", {31'h0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_rst", {31'h0, core_rst}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_error", {31'h0, error}, 32'd0);
        check("rst_wl", {23'h0, words_loaded}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h05;
        repeat (3) begin @(posedge CLK); #1; end
        check("idle_in_ready", {31'h0, in_ready}, 32'd0);
        check("idle_busy", {31'h0, busy}, 32'd0);
        in_valid = 1'b0;

        // Normal 2-word load, back-to-back.
        clear_writes();
        pulse_start();
        check("start_lat_ready", {31'h0, in_ready}, 32'd1);
        send_frame(2, 8'h90, 0, -1);
        check("ok_done", {31'h0, done}, 32'd1);
        check("ok_error", {31'h0, error}, 32'd0);
        check("ok_core_rst", {31'h0, core_rst}, 32'd0);
        check("ok_wl", {23'h0, words_loaded}, 32'd2);
        check_two_words("ok");

        // Start from DONE, then bad checksum.
        clear_writes();
        pulse_start();
        check("redo_done", {31'h0, done}, 32'd0);
        check("redo_core_rst", {31'h0, core_rst}, 32'd1);
        check("redo_wl", {23'h0, words_loaded}, 32'd0);
        send_frame(2, 8'h91, 0, -1);
        check("bad_error", {31'h0, error}, 32'd1);
        check("bad_done", {31'h0, done}, 32'd0);
        check("bad_core_rst", {31'h0, core_rst}, 32'd1);
        check_two_words("bad");

        // N = 0.
        clear_writes();
        pulse_start();
        send_frame(0, 8'h00, 0, -1);
        check("n0_done", {31'h0, done}, 32'd1);
        check("n0_nwr", wa_q.size(), 32'd0);
        check("n0_wl", {23'h0, words_loaded}, 32'd0);

        // N = 257 rejected immediately after LEN_HI.
        clear_writes();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        in_valid = 1'b0;
        check("n257_error", {31'h0, error}, 32'd1);
        check("n257_ready", {31'h0, in_ready}, 32'd0);
        repeat (3) begin @(posedge CLK); #1; end
        check("n257_nwr", wa_q.size(), 32'd0);

        // N = 256, full capacity.
        clear_writes();
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            img[i] = (32'h0101_0101 * i) ^ 32'hA55A_3CC3;
            cs = cs ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        end
        pulse_start();
        send_frame(256, cs, 0, -1);
        check("n256_done", {31'h0, done}, 32'd1);
        check("n256_wl", {23'h0, words_loaded}, 32'd256);
        check("n256_nwr", wa_q.size(), 32'd256);
        if (wa_q.size() == 256) begin
            check("n256_last_addr", wa_q[255], 32'h0000_00FF);
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (wa_q[i] !== i || wd_q[i] !== img[i]) bad++;
            end
            check("n256_words_bad", bad, 32'd0);
        end

        // Random gaps plus a start pulse mid-DATA.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        clear_writes();
        pulse_start();
        send_frame(2, 8'h90, 3, 2);
        check("stall_done", {31'h0, done}, 32'd1);
        check("stall_wl", {23'h0, words_loaded}, 32'd2);
        check_two_words("stall");

        // Reset after 5 payload bytes.
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 5; k++) send_byte(img[k / 4][8 * (k % 4) +: 8], 0);
        in_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("mid_rst_we", {31'h0, mem_we}, 32'd0);
        check("mid_rst_core_rst", {31'h0, core_rst}, 32'd1);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_ready", {31'h0, in_ready}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_writes();
        pulse_start();
        send_frame(2, 8'h90, 0, -1);
        check("after_rst_done", {31'h0, done}, 32'd1);
        check_two_words("after_rst");

        repeat (2) begin @(posedge CLK); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Hardware boot loader that fills the instruction ROM from a byte stream, replacing simulation-only `$readmemh` and hierarchical ROM pokes. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the instruction-memory write port at consecutive word addresses. The CPU core is held in reset until the image has been loaded and its checksum verified.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is `2**ADDR_W` words.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset. One clock domain.
- `start` in 1: single-cycle pulse that begins a load.
- `in_valid` in 1: a byte is offered on `in_data`.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte this cycle.
- `mem_we` out 1: instruction-memory write strobe.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: instruction word.
- `core_rst` out 1: active-high reset to the CPU core.
- `busy` out 1: a load is in progress.
- `done` out 1: load completed and checksum matched.
- `error` out 1: load aborted.
- `words_loaded` out ADDR_W+1: number of words written in the current or last load.

## Operation

Frame format:
- LEN_LO, LEN_HI: 16-bit word count N, little-endian.
- 4·N payload bytes. Each word is sent LSB first, so byte k of a word maps to bits [8k+7:8k].
- CSUM: XOR of all payload bytes. The CSUM byte for N=0 is 0x00.

Byte acceptance:
- A byte is consumed on a rising edge where `in_valid && in_ready`.
- `in_ready` = 1 only in LEN_LO, LEN_HI, DATA and CSUM.

States:
- IDLE: waits for `start`. Transitions to LEN_LO.
- LEN_LO: on accept, latch low byte. Transitions to LEN_HI.
- LEN_HI: on accept, latch high byte, then:
  - N > `2**ADDR_W`: go to ERR.
  - N = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: accumulate bytes into a 32-bit shift/assembly register and fold each byte into the running XOR.
  - On the 4th byte of a word, issue the write and increment the word index.
  - After word N-1, go to CSUM.
- CSUM: on accept, compare against the running XOR. Match: go to DONE. Mismatch: go to ERR.
- DONE: `done`=1, `core_rst`=0. `start` begins a new load (go to LEN_LO).
- ERR: `error`=1, `core_rst`=1. `start` begins a new load.

On entering LEN_LO, all of the following are cleared: word index, `words_loaded`, byte counter, running XOR, `done`, `error`.

Output rules:
- `busy` = 1 in LEN_LO, LEN_HI, DATA and CSUM.
- `core_rst` = 1 in every state except DONE.
- `start` is ignored while `busy`.
- Words already written before an ERR remain in memory. No rollback.
- The word index (`mem_addr`) never wraps, because N is bounded before DATA is entered.

## Timing

Reset values (asynchronous, immediate):
- State = IDLE
- `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
- `core_rst`=1, `busy`=0, `done`=0, `error`=0, `words_loaded`=0

Latency:
- `start` in cycle t puts the block in LEN_LO, so `in_ready`=1 in t+1.
- One byte can be accepted per cycle. Back-to-back `in_valid` sustains 1 byte/clock.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- `words_loaded` increments in the same cycle that `mem_we` is high.
- The CSUM byte accepted in cycle t gives `done` or `error` = 1 in t+1. `core_rst` falls in t+1 on a match.
- `in_valid` low stalls the loader with no state change.

Reset during a load:
- Aborts the load immediately; the block returns to IDLE.
- `core_rst` returns to 1.
- Any pending `mem_we` is dropped.

## Test plan

- **Reset values:** Hold `RST` high, then release → all outputs equal their reset values, `core_rst`=1, `in_ready`=0. Bytes offered in IDLE are not consumed.
- **Normal 2-word load:** `start`, then bytes 02 00, 13 00 00 00, 93 00 10 00, checksum 0x90, all back-to-back →
  - `mem_we` pulses at addr 0 with 0x00000013, then at addr 1 with 0x00100093.
  - `done`=1, `core_rst`=0, `words_loaded`=2.
- **Bad checksum:** Same frame with checksum 0x91 → `error`=1, `core_rst`=1, `done`=0. Both words remain written.
- **Boundary lengths:**
  - N=0 with CSUM 00 → DONE with no `mem_we`.
  - N=`2**ADDR_W`+1 (0x0101 for ADDR_W=8) → ERR right after LEN_HI, no writes.
  - N=256 → last write at addr 0xFF, `words_loaded`=256.
- **Stall and protocol:**
  - Random `in_valid` gaps → identical writes and result as back-to-back.
  - `start` pulsed mid-DATA → ignored.
  - `start` in DONE → new load, `done` cleared, `core_rst` back to 1.
- **Reset mid-load:** Assert `RST` after 5 payload bytes → IDLE, `mem_we`=0, `core_rst`=1. A following full load succeeds from addr 0.
